// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: stage stall requests, MUL/DIV start and exception in; stall vector, flush and MUL/DIV status out.
// Latency: wires only, no state.
// Backpressure: none here; the stall vector carried back to the stages is the backpressure.
// Ports: master = stage side (drives requests, reads controls); slave = pipeline_ctrl.
// PIPE_CTRL_PERF_EN adds the perf_* counter outputs to the bundle.
interface pipeline_ctrl_if;
    logic        stall_req_if;
    logic        stall_req_id;
    logic        stall_req_mem;
    logic        muldiv_start;
    logic        muldiv_is_div;
    logic        exception_flag;
    logic [31:0] exception_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        muldiv_busy;
    logic        muldiv_done;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_flush_count;
    logic [31:0] perf_muldiv_cycles;

    modport master (
        output stall_req_if, stall_req_id, stall_req_mem,
        output muldiv_start, muldiv_is_div, exception_flag, exception_pc,
        input  stall, flush, flush_pc, muldiv_busy, muldiv_done,
        input  perf_stall_cycles, perf_flush_count, perf_muldiv_cycles
    );

    modport slave (
        input  stall_req_if, stall_req_id, stall_req_mem,
        input  muldiv_start, muldiv_is_div, exception_flag, exception_pc,
        output stall, flush, flush_pc, muldiv_busy, muldiv_done,
        output perf_stall_cycles, perf_flush_count, perf_muldiv_cycles
    );
`else
    modport master (
        output stall_req_if, stall_req_id, stall_req_mem,
        output muldiv_start, muldiv_is_div, exception_flag, exception_pc,
        input  stall, flush, flush_pc, muldiv_busy, muldiv_done
    );

    modport slave (
        input  stall_req_if, stall_req_id, stall_req_mem,
        input  muldiv_start, muldiv_is_div, exception_flag, exception_pc,
        output stall, flush, flush_pc, muldiv_busy, muldiv_done
    );
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline; sequences MUL/DIV in EX and defers flush while MEM is busy.
// Latency: stall/flush/flush_pc/muldiv_done are combinational in the request cycle; state advances on clk.
// Backpressure: highest stalled stage holds itself and all earlier stages and bubbles the next one.
// Ports: clk, rst (async, active-high); ctrl (pipeline_ctrl_if.slave) carries all requests and controls.
// Optional: define PIPE_CTRL_PERF_EN for stall/flush/muldiv performance counters.
module pipeline_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  ctrl
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MULDIV     = 2'd1,
        FLUSH_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 flush_pending_q, flush_pending_d;
    logic [31:0]          pend_pc_q, pend_pc_d;

    logic [CNT_WIDTH-1:0] load_val;
    logic                 ex_busy;
    logic                 busy;
    logic                 done;
    logic                 flush;
    logic [31:0]          flush_pc;
    logic [5:0]           stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            pend_pc_q       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            pend_pc_q       <= pend_pc_d;
        end
    end

    // The start cycle is the first of the N EX-held cycles, so the counter is
    // loaded with N-1 "cycles still to go" and the op completes on the
    // MULDIV cycle that would take it from 1 to 0.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        flush_pending_d = flush_pending_q;
        pend_pc_d       = pend_pc_q;
        flush           = 1'b0;
        flush_pc        = '0;
        done            = 1'b0;
        busy            = (state_q == MULDIV);
        ex_busy         = busy || ((state_q == IDLE) && ctrl.muldiv_start);
        load_val        = ctrl.muldiv_is_div ? DIV_LOAD : MUL_LOAD;

        case (state_q)
            IDLE: begin
                if (ctrl.exception_flag) begin
                    if (!ctrl.stall_req_mem) begin
                        flush    = 1'b1;
                        flush_pc = ctrl.exception_pc;
                    end else begin
                        flush_pending_d = 1'b1;
                        pend_pc_d       = ctrl.exception_pc;
                        state_d         = FLUSH_WAIT;
                    end
                end else if (ctrl.muldiv_start) begin
                    if (load_val == '0) begin
                        done = 1'b1;
                    end else begin
                        cnt_d   = load_val;
                        state_d = MULDIV;
                    end
                end
            end
            MULDIV: begin
                if (ctrl.exception_flag) begin
                    // Exception aborts the op without a done pulse.
                    cnt_d = '0;
                    if (!ctrl.stall_req_mem) begin
                        flush    = 1'b1;
                        flush_pc = ctrl.exception_pc;
                        state_d  = IDLE;
                    end else begin
                        flush_pending_d = 1'b1;
                        pend_pc_d       = ctrl.exception_pc;
                        state_d         = FLUSH_WAIT;
                    end
                end else if (!ctrl.stall_req_mem) begin
                    if (cnt_q <= CNT_ONE) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            FLUSH_WAIT: begin
                // Later exceptions are ignored: the first latched pc wins.
                if (!ctrl.stall_req_mem) begin
                    flush           = 1'b1;
                    flush_pc        = pend_pc_q;
                    flush_pending_d = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (flush) begin
            stall = 6'b000000;
        end else if (ctrl.stall_req_mem || flush_pending_q) begin
            stall = 6'b011111;
        end else if (ex_busy) begin
            stall = 6'b001111;
        end else if (ctrl.stall_req_id) begin
            stall = 6'b000111;
        end else if (ctrl.stall_req_if) begin
            stall = 6'b000011;
        end else begin
            stall = 6'b000000;
        end
    end

    assign ctrl.stall       = stall;
    assign ctrl.flush       = flush;
    assign ctrl.flush_pc    = flush_pc;
    assign ctrl.muldiv_busy = busy;
    assign ctrl.muldiv_done = done;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_md_q, perf_md_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_md_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_md_q    <= perf_md_d;
        end
    end

    // Counters wrap naturally at their maximum value.
    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall[0]};
        perf_flush_d = perf_flush_q + {15'd0, flush};
        perf_md_d    = perf_md_q + {31'd0, busy};
    end

    assign ctrl.perf_stall_cycles  = perf_stall_q;
    assign ctrl.perf_flush_count   = perf_flush_q;
    assign ctrl.perf_muldiv_cycles = perf_md_q;
`endif

endmodule
